// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA TX path: channel indices, arbiter FSM states, default priority order.
// Optional build macro IPS2L_PCIE_DMA_TX_ARB_RR_EN selects round-robin arbitration in users of this package.
package ips2l_pcie_dma_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 128;

    localparam logic [1:0] CH_CPLD = 2'd0;
    localparam logic [1:0] CH_MRD  = 2'd1;
    localparam logic [1:0] CH_MWR  = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Default priority: rank 0 is served first.
    function automatic logic [1:0] prio_ch(input logic [1:0] rank);
        case (rank)
            2'd0:    prio_ch = CH_CPLD;
            2'd1:    prio_ch = CH_MWR;
            default: prio_ch = CH_MRD;
        endcase
    endfunction

    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        ch_onehot = 3'b001 << ch;
    endfunction

    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        case (oh)
            3'b001:  oh_to_idx = 2'd0;
            3'b010:  oh_to_idx = 2'd1;
            default: oh_to_idx = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        case (ch)
            2'd0:    next_ch = 2'd1;
            2'd1:    next_ch = 2'd2;
            default: next_ch = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ips2l_pcie_dma_tx_arb_sel.sv
// Combinational grant selection for the DMA TX arbiter: request vector in, one-hot grant out.
// sel_ctl carries the aged-channel vector, or the last grant when IPS2L_PCIE_DMA_TX_ARB_RR_EN is defined.
module ips2l_pcie_dma_tx_arb_sel
    import ips2l_pcie_dma_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] sel_ctl,
    output logic [2:0] grant
);

`ifdef IPS2L_PCIE_DMA_TX_ARB_RR_EN

    logic [1:0] last_s;
    logic [1:0] c1_s;
    logic [1:0] c2_s;
    logic [1:0] c3_s;

    // Round-robin: search starts at the channel after the last granted one.
    always_comb begin
        last_s = oh_to_idx(sel_ctl);
        c1_s   = next_ch(last_s);
        c2_s   = next_ch(c1_s);
        c3_s   = next_ch(c2_s);
        if (req[c1_s]) begin
            grant = ch_onehot(c1_s);
        end else if (req[c2_s]) begin
            grant = ch_onehot(c2_s);
        end else if (req[c3_s]) begin
            grant = ch_onehot(c3_s);
        end else begin
            grant = 3'b000;
        end
    end

`else

    logic [2:0] aged_req_s;

    function automatic logic [2:0] pick_fixed(input logic [2:0] v);
        if (v[prio_ch(2'd0)]) begin
            pick_fixed = ch_onehot(prio_ch(2'd0));
        end else if (v[prio_ch(2'd1)]) begin
            pick_fixed = ch_onehot(prio_ch(2'd1));
        end else if (v[prio_ch(2'd2)]) begin
            pick_fixed = ch_onehot(prio_ch(2'd2));
        end else begin
            pick_fixed = 3'b000;
        end
    endfunction

    // Aged requesters pre-empt the fixed order; fixed order breaks ties among them.
    always_comb begin
        aged_req_s = req & sel_ctl;
        if (|aged_req_s) begin
            grant = pick_fixed(aged_req_s);
        end else begin
            grant = pick_fixed(req);
        end
    end

`endif

endmodule

// File: rtl/ips2l_pcie_dma_tx_arbiter.sv
// Packet-granular arbiter merging the CPLD/MRD/MWR TLP streams onto the single core TX AXI-stream port.
// Define IPS2L_PCIE_DMA_TX_ARB_RR_EN for round-robin selection (no aging); default is fixed priority with aging.
module ips2l_pcie_dma_tx_arbiter
    import ips2l_pcie_dma_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           i_s_tvld,
    input  logic [383:0]         i_s_tdata,
    input  logic [2:0]           i_s_tlast,
    input  logic [2:0]           i_s_tuser,
    output logic [2:0]           o_s_trdy,
    output logic                 o_m_tvld,
    output logic [127:0]         o_m_tdata,
    output logic                 o_m_tlast,
    output logic                 o_m_tuser,
    input  logic                 i_m_trdy,
    output logic [2:0]           o_grant,
    output logic                 o_busy,
    input  logic                 i_tx_restart,
    output logic [CNT_WIDTH-1:0] o_tlp_cnt0,
    output logic [CNT_WIDTH-1:0] o_tlp_cnt1,
    output logic [CNT_WIDTH-1:0] o_tlp_cnt2
);

    arb_state_e           state_r;
    arb_state_e           state_nxt_s;
    logic [2:0]           grant_r;
    logic [2:0]           grant_nxt_s;
    logic [2:0]           sel_grant_s;
    logic [2:0]           sel_hint_s;
    logic                 busy_r;
    logic                 xfer_s;
    logic                 arb_s;
    logic                 last_acc_s;
    logic [CNT_WIDTH-1:0] cnt_r [NUM_CH];

    assign xfer_s = (state_r == ST_XFER);
    assign arb_s  = (state_r == ST_IDLE) & (|i_s_tvld);

    ips2l_pcie_dma_tx_arb_sel u_sel (
        .req     (i_s_tvld),
        .sel_ctl (sel_hint_s),
        .grant   (sel_grant_s)
    );

    // Datapath mux driven by the registered grant; everything reads zero outside XFER.
    always_comb begin
        o_m_tvld  = 1'b0;
        o_m_tdata = 128'd0;
        o_m_tlast = 1'b0;
        o_m_tuser = 1'b0;
        o_s_trdy  = 3'b000;
        for (int k = 0; k < NUM_CH; k++) begin
            o_m_tvld    |= xfer_s & grant_r[k] & i_s_tvld[k];
            o_m_tdata   |= {DATA_W{xfer_s & grant_r[k]}} & i_s_tdata[DATA_W*k +: DATA_W];
            o_m_tlast   |= xfer_s & grant_r[k] & i_s_tlast[k];
            o_m_tuser   |= xfer_s & grant_r[k] & i_s_tuser[k];
            o_s_trdy[k]  = xfer_s & grant_r[k] & i_m_trdy;
        end
    end

    assign last_acc_s = o_m_tvld & i_m_trdy & o_m_tlast;

    // Next-state: grant is taken in IDLE and held until the tlast beat is accepted.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_s_tvld) begin
                    state_nxt_s = ST_XFER;
                    grant_nxt_s = sel_grant_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 3'b000;
                end
            end
            ST_XFER: begin
                if (last_acc_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 3'b000;
                end else begin
                    state_nxt_s = ST_XFER;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = 3'b000;
            end
        endcase
    end

    // FSM, grant and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= 3'b000;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            busy_r  <= (state_nxt_s == ST_XFER);
        end
    end

`ifdef IPS2L_PCIE_DMA_TX_ARB_RR_EN

    logic [2:0] last_r;

    // Last-grant pointer; reset to channel 2 so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 3'b100;
        end else if (arb_s) begin
            last_r <= sel_grant_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign sel_hint_s = last_r;

`else

    localparam logic [7:0] AGE_MAX = 8'(MAX_WAIT);

    logic [7:0] age_r [NUM_CH];

    // Aging: count lost arbitrations, saturate at AGE_MAX, clear on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                age_r[k] <= 8'd0;
            end
        end else if (arb_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel_grant_s[k]) begin
                    age_r[k] <= 8'd0;
                end else if (i_s_tvld[k] && (age_r[k] != AGE_MAX)) begin
                    age_r[k] <= age_r[k] + 8'd1;
                end else begin
                    age_r[k] <= age_r[k];
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                age_r[k] <= age_r[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sel_hint_s[k] = (age_r[k] == AGE_MAX);
        end
    end

`endif

    // Completed-TLP counters; restart beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_tx_restart) begin
                    cnt_r[k] <= {CNT_WIDTH{1'b0}};
                end else if (last_acc_s && grant_r[k]) begin
                    cnt_r[k] <= cnt_r[k] + CNT_WIDTH'(1'b1);
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    assign o_grant    = grant_r;
    assign o_busy     = busy_r;
    assign o_tlp_cnt0 = cnt_r[0];
    assign o_tlp_cnt1 = cnt_r[1];
    assign o_tlp_cnt2 = cnt_r[2];

endmodule

// File: tb/tb_ips2l_pcie_dma_tx_arbiter.sv
// Directed bench for ips2l_pcie_dma_tx_arbiter; expectations follow IPS2L_PCIE_DMA_TX_ARB_RR_EN when defined.
// A second instance with 4-bit counters shares the stimulus so counter wrap is reachable quickly.
module tb_ips2l_pcie_dma_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   s_tvld;
    logic [383:0] s_tdata;
    logic [2:0]   s_tlast;
    logic [2:0]   s_tuser;
    logic         m_trdy;
    logic         tx_restart;

    logic [2:0]   s_trdy, grant;
    logic         m_tvld, m_tlast, m_tuser, busy;
    logic [127:0] m_tdata;
    logic [15:0]  cnt0, cnt1, cnt2;

    logic [2:0]   w_s_trdy, w_grant;
    logic         w_m_tvld, w_m_tlast, w_m_tuser, w_busy;
    logic [127:0] w_m_tdata;
    logic [3:0]   w_cnt0, w_cnt1, w_cnt2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ips2l_pcie_dma_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_s_tvld(s_tvld), .i_s_tdata(s_tdata), .i_s_tlast(s_tlast), .i_s_tuser(s_tuser),
        .o_s_trdy(s_trdy), .o_m_tvld(m_tvld), .o_m_tdata(m_tdata), .o_m_tlast(m_tlast),
        .o_m_tuser(m_tuser), .i_m_trdy(m_trdy), .o_grant(grant), .o_busy(busy),
        .i_tx_restart(tx_restart), .o_tlp_cnt0(cnt0), .o_tlp_cnt1(cnt1), .o_tlp_cnt2(cnt2)
    );

    ips2l_pcie_dma_tx_arbiter #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .i_s_tvld(s_tvld), .i_s_tdata(s_tdata), .i_s_tlast(s_tlast), .i_s_tuser(s_tuser),
        .o_s_trdy(w_s_trdy), .o_m_tvld(w_m_tvld), .o_m_tdata(w_m_tdata), .o_m_tlast(w_m_tlast),
        .o_m_tuser(w_m_tuser), .i_m_trdy(m_trdy), .o_grant(w_grant), .o_busy(w_busy),
        .i_tx_restart(tx_restart), .o_tlp_cnt0(w_cnt0), .o_tlp_cnt1(w_cnt1), .o_tlp_cnt2(w_cnt2)
    );

    typedef struct {
        logic [2:0]  tvld;
        logic [2:0]  tlast;
        int          beat;
        logic        trdy;
        logic        exp_tvld;
        logic        exp_tlast;
        logic [2:0]  exp_grant;
        logic [2:0]  exp_strdy;
        logic        exp_busy;
        logic [15:0] exp_cnt2;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [127:0] tdat(input int ch, input int b);
        tdat = {8'hD0, 88'd0, 16'(ch), 16'(b)};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic data_all(input int b);
        s_tdata = {tdat(2, b), tdat(1, b), tdat(0, b)};
    endtask

    task automatic single(input int k, input logic rs);
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        s_tvld[k] = 1'b1;
        s_tlast[k] = 1'b1;
        data_all(0);
        m_trdy = 1'b1;
        cyc();
        tx_restart = rs;
        cyc();
        tx_restart = 1'b0;
        s_tvld = 3'b000;
        s_tlast = 3'b000;
    endtask

    initial begin
        int beat [3];
        int ord [3];
        logic [2:0] acc;
        logic [2:0] eg;
        int seg;
        int pos;
        int ch;
`ifdef IPS2L_PCIE_DMA_TX_ARB_RR_EN
        ord = '{0, 1, 2};
`else
        ord = '{0, 2, 1};
`endif

        tbl[0] = '{3'b100, 3'b000, 0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'd0};
        tbl[1] = '{3'b100, 3'b000, 0, 1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 1'b1, 16'd0};
        tbl[2] = '{3'b100, 3'b000, 1, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 16'd0};
        tbl[3] = '{3'b100, 3'b000, 1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b100, 1'b1, 16'd0};
        tbl[4] = '{3'b100, 3'b100, 2, 1'b0, 1'b1, 1'b1, 3'b100, 3'b000, 1'b1, 16'd0};
        tbl[5] = '{3'b100, 3'b100, 2, 1'b1, 1'b1, 1'b1, 3'b100, 3'b100, 1'b1, 16'd0};
        tbl[6] = '{3'b000, 3'b000, 0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'd1};

        rst_n = 1'b0;
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        s_tuser = 3'b000;
        s_tdata = 384'd0;
        m_trdy = 1'b1;
        tx_restart = 1'b0;
        repeat (3) cyc();
        check("rst_grant", 128'(grant), 128'(3'b000));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_m_tvld", 128'(m_tvld), 128'(1'b0));
        check("rst_m_tdata", m_tdata, 128'd0);
        check("rst_s_trdy", 128'(s_trdy), 128'(3'b000));
        check("rst_cnt", 128'({cnt0, cnt1, cnt2}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Three simultaneous 4-beat TLPs.
        beat = '{0, 0, 0};
        s_tuser = 3'b101;
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 3; k++) begin
                s_tvld[k] = (beat[k] < 4);
                s_tlast[k] = (beat[k] == 3);
                s_tdata[128*k +: 128] = tdat(k, beat[k]);
            end
            #1;
            seg = t / 5;
            pos = t % 5;
            eg = (pos == 0 || seg > 2) ? 3'b000 : (3'b001 << ord[seg]);
            check("multi_grant", 128'(grant), 128'(eg));
            check("multi_m_tvld", 128'(m_tvld), 128'(eg != 3'b000));
            if (eg != 3'b000) begin
                check("multi_m_tdata", m_tdata, tdat(ord[seg], pos - 1));
                check("multi_m_tlast", 128'(m_tlast), 128'(pos == 4));
                check("multi_m_tuser", 128'(m_tuser), 128'(ord[seg] != 1));
            end
            acc = s_tvld & s_trdy;
            cyc();
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) beat[k]++;
            end
        end
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        s_tuser = 3'b000;
        check("multi_cnt0", 128'(cnt0), 128'(16'd1));
        check("multi_cnt1", 128'(cnt1), 128'(16'd1));
        check("multi_cnt2", 128'(cnt2), 128'(16'd1));

        // Reset on beat 2 of a 4-beat CPLD TLP.
        s_tvld = 3'b001;
        data_all(0);
        cyc();
        cyc();
        data_all(1);
        cyc();
        data_all(2);
        #2;
        check("pre_rst_m_tvld", 128'(m_tvld), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check("async_m_tvld", 128'(m_tvld), 128'(1'b0));
        check("async_grant", 128'(grant), 128'(3'b000));
        check("async_busy", 128'(busy), 128'(1'b0));
        check("async_s_trdy", 128'(s_trdy), 128'(3'b000));
        check("async_cnt", 128'({cnt0, cnt1, cnt2}), 128'd0);
        s_tvld = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        s_tvld = 3'b100;
        s_tlast = 3'b100;
        cyc();
        check("resume_grant", 128'(grant), 128'(3'b100));
        cyc();
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        check("resume_cnt2", 128'(cnt2), 128'(16'd1));
        check("resume_cnt0", 128'(cnt0), 128'(16'd0));

        tx_restart = 1'b1;
        cyc();
        tx_restart = 1'b0;
        check("restart_cnt2", 128'(cnt2), 128'(16'd0));

        // MWR 3-beat TLP with core ready toggling.
        for (int i = 0; i < 7; i++) begin
            s_tvld = tbl[i].tvld;
            s_tlast = tbl[i].tlast;
            m_trdy = tbl[i].trdy;
            data_all(tbl[i].beat);
            #1;
            ch = tbl[i].exp_grant[2] ? 2 : (tbl[i].exp_grant[1] ? 1 : 0);
            check("tbl_m_tvld", 128'(m_tvld), 128'(tbl[i].exp_tvld));
            check("tbl_m_tlast", 128'(m_tlast), 128'(tbl[i].exp_tlast));
            check("tbl_grant", 128'(grant), 128'(tbl[i].exp_grant));
            check("tbl_s_trdy", 128'(s_trdy), 128'(tbl[i].exp_strdy));
            check("tbl_busy", 128'(busy), 128'(tbl[i].exp_busy));
            check("tbl_cnt2", 128'(cnt2), 128'(tbl[i].exp_cnt2));
            check("tbl_m_tdata", m_tdata,
                  (tbl[i].exp_grant != 3'b000) ? tdat(ch, tbl[i].beat) : 128'd0);
            cyc();
        end
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        m_trdy = 1'b1;

        // Counter wrap on the 4-bit instance, then restart coincident with tlast.
        tx_restart = 1'b1;
        cyc();
        tx_restart = 1'b0;
        repeat (15) single(0, 1'b0);
        check("wrap_w_cnt0_full", 128'(w_cnt0), 128'(4'hF));
        check("wrap_cnt0_15", 128'(cnt0), 128'(16'd15));
        single(0, 1'b0);
        check("wrap_w_cnt0_zero", 128'(w_cnt0), 128'(4'h0));
        check("wrap_cnt0_16", 128'(cnt0), 128'(16'd16));
        single(0, 1'b1);
        check("restart_vs_tlast", 128'(cnt0), 128'(16'd0));
        check("restart_vs_tlast_w", 128'(w_cnt0), 128'(4'h0));
        single(0, 1'b0);
        check("after_restart_cnt0", 128'(cnt0), 128'(16'd1));

`ifdef IPS2L_PCIE_DMA_TX_ARB_RR_EN
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        s_tvld = 3'b111;
        s_tlast = 3'b111;
        data_all(0);
        for (int n = 0; n < 6; n++) begin
            cyc();
            check("rr_grant", 128'(grant), 128'(3'b001 << (n % 3)));
            cyc();
        end
        s_tvld = 3'b000;
        s_tlast = 3'b000;
`else
        // CPLD floods single-beat TLPs while MRD waits; MRD wins every 17th arbitration.
        tx_restart = 1'b1;
        cyc();
        tx_restart = 1'b0;
        s_tvld = 3'b011;
        s_tlast = 3'b011;
        data_all(0);
        for (int n = 1; n <= 34; n++) begin
            cyc();
            check("aging_grant", 128'(grant),
                  128'((n == 17 || n == 34) ? 3'b010 : 3'b001));
            cyc();
        end
        s_tvld = 3'b000;
        s_tlast = 3'b000;
        check("aging_cnt0", 128'(cnt0), 128'(16'd32));
        check("aging_cnt1", 128'(cnt1), 128'(16'd2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
